// File: rtl/hazard_forward_unit_if.sv
// Pipeline-side bundle for the KLP32 forwarding/hazard unit.
// The pipeline drives stage qualifiers as master; the unit answers with selects and stalls as slave.
interface hazard_forward_unit_if #(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 16
);
   logic                 d_valid, d_uses_rs1, d_uses_rs2, d_we;
   logic [REG_AW-1:0]    d_rs1, d_rs2, d_rd;
   logic                 x_valid, x_we, x_is_load, x_is_long;
   logic [REG_AW-1:0]    x_rs1, x_rs2, x_rd;
   logic                 m_valid, m_we;
   logic [REG_AW-1:0]    m_rs2, m_rd;
   logic                 w_valid, w_we;
   logic [REG_AW-1:0]    w_rd;
   logic                 lw_valid;
   logic [REG_AW-1:0]    lw_rd;
   logic                 flush;
   logic [1:0]           a_sel, b_sel;
   logic                 data_sel;
   logic                 stall_d;
   logic                 bubble_x;
   logic [2**REG_AW-1:0] sb_busy;
   logic [CNT_W-1:0]     stall_cnt;

   modport master (
      output d_valid, d_uses_rs1, d_uses_rs2, d_we, d_rs1, d_rs2, d_rd,
      output x_valid, x_we, x_is_load, x_is_long, x_rs1, x_rs2, x_rd,
      output m_valid, m_we, m_rs2, m_rd, w_valid, w_we, w_rd,
      output lw_valid, lw_rd, flush,
      input  a_sel, b_sel, data_sel, stall_d, bubble_x, sb_busy, stall_cnt
   );

   modport slave (
      input  d_valid, d_uses_rs1, d_uses_rs2, d_we, d_rs1, d_rs2, d_rd,
      input  x_valid, x_we, x_is_load, x_is_long, x_rs1, x_rs2, x_rd,
      input  m_valid, m_we, m_rs2, m_rd, w_valid, w_we, w_rd,
      input  lw_valid, lw_rd, flush,
      output a_sel, b_sel, data_sel, stall_d, bubble_x, sb_busy, stall_cnt
   );
endinterface

// File: rtl/hazard_forward_unit.sv
// KLP32 operand/store-data bypass selection, load-use and long-latency hazard detection,
// long-op destination scoreboard and saturating decode-stall counter.
module hazard_forward_unit #(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 16
) (
   input logic               clk,
   input logic               rst,
   hazard_forward_unit_if.slave hz
);
   localparam int unsigned NREG = 2**REG_AW;

   logic [NREG-1:0]  busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             m_live, w_live, x_load_live;
   logic             load_use, raw_long, waw_long, stall;
   logic             long_issue;

   assign m_live      = hz.m_valid & hz.m_we & (hz.m_rd != '0);
   assign w_live      = hz.w_valid & hz.w_we & (hz.w_rd != '0);
   assign x_load_live = hz.x_valid & hz.x_is_load & hz.x_we & (hz.x_rd != '0);
   assign long_issue  = hz.x_valid & hz.x_is_long & hz.x_we;

   // M is the younger producer, so it wins over W
   always_comb begin
      hz.a_sel = 2'b00;
      if (m_live && hz.m_rd == hz.x_rs1)      hz.a_sel = 2'b01;
      else if (w_live && hz.w_rd == hz.x_rs1) hz.a_sel = 2'b10;
      hz.b_sel = 2'b00;
      if (m_live && hz.m_rd == hz.x_rs2)      hz.b_sel = 2'b01;
      else if (w_live && hz.w_rd == hz.x_rs2) hz.b_sel = 2'b10;
   end

   assign hz.data_sel = w_live & (hz.w_rd == hz.m_rs2);

   assign load_use = x_load_live &
                     ((hz.d_uses_rs1 & (hz.x_rd == hz.d_rs1)) |
                      (hz.d_uses_rs2 & (hz.x_rd == hz.d_rs2)));
   assign raw_long = (busy_q[hz.d_rs1] & hz.d_uses_rs1) |
                     (busy_q[hz.d_rs2] & hz.d_uses_rs2);
   assign waw_long = hz.d_we & busy_q[hz.d_rd];

   assign stall       = hz.d_valid & (load_use | raw_long | waw_long) & ~hz.flush;
   assign hz.stall_d  = stall;
   assign hz.bubble_x = stall;

   // A newly issued long op owns its register even if an older one retires the same cycle
   always_comb begin
      busy_d = '0;
      for (int unsigned r = 1; r < NREG; r++) begin
         busy_d[r] = (long_issue & (hz.x_rd == REG_AW'(r))) |
                     (busy_q[r] & ~(hz.lw_valid & (hz.lw_rd == REG_AW'(r))));
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (stall && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   assign hz.sb_busy   = busy_q;
   assign hz.stall_cnt = cnt_q;
endmodule
